// File: rtl/dmem_responder_if.sv
// Request/response bus between a MIPS-lite core (master) and the data memory
// responder (slave).
//
// Handshake: a transfer on either channel happens on a rising clk edge where
// both valid and ready are high. The master keeps req_* stable while
// req_valid is high and may drop req_valid before acceptance. The slave keeps
// rsp_rdata/rsp_err stable while rsp_valid is high and rsp_ready is low.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-wide big-endian data memory responder with configurable wait states.
// One request in flight: IDLE -> WAIT (skipped when WAIT_CYCLES=0) -> ACCESS
// -> RESP -> IDLE. Byte indices wrap modulo DEPTH_BYTES.
// Optional feature macro: DMEM_ALIGN_CHECK_EN rejects word accesses whose
// address is not 4-byte aligned (rsp_err=1, no memory access).
module dmem_responder #(
  parameter int DEPTH_BYTES = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_responder_if.slave   bus,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [CW-1:0]   wait_cnt;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic            err_q;
  logic            misaligned;
  logic            accept;
  logic [AW-1:0]   a0, a1, a2, a3;
  logic [7:0]      mem [DEPTH_BYTES];

  assign accept    = (state == S_IDLE) && bus.req_valid;
  assign state_dbg = state;

  // Byte lanes of the latched word; AW-bit adds wrap around the array.
  assign a0 = addr_q;
  assign a1 = addr_q + AW'(1);
  assign a2 = addr_q + AW'(2);
  assign a3 = addr_q + AW'(3);

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = (addr_q[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state logic; RESP never accepts a new request, even with rsp_ready.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:   if (bus.req_valid) state_n = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
      S_WAIT:   if (wait_cnt == '0) state_n = S_ACCESS;
      S_ACCESS: state_n = S_RESP;
      S_RESP:   if (bus.rsp_ready) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    busy          = 1'b1;
    unique case (state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        busy          = 1'b0;
      end
      S_RESP:  bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Wait-state down-counter, loaded when a request is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (accept) begin
      wait_cnt <= WAIT_LOAD;
    end else if ((state == S_WAIT) && (wait_cnt != '0)) begin
      wait_cnt <= wait_cnt - CW'(1);
    end
  end

  // Request capture on acceptance; inputs are ignored afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= bus.req_we;
      addr_q  <= bus.req_addr[AW-1:0];
      wdata_q <= bus.req_wdata;
    end
  end

  // Storage and response registers: all four store bytes commit on the
  // ACCESS exit edge, so a reset before that edge discards the whole word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_BYTES; i++) mem[i] <= 8'h00;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state == S_ACCESS) begin
      if (misaligned) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end else if (we_q) begin
        mem[a0] <= wdata_q[31:24];
        mem[a1] <= wdata_q[23:16];
        mem[a2] <= wdata_q[15:8];
        mem[a3] <= wdata_q[7:0];
        rdata_q <= '0;
        err_q   <= 1'b0;
      end else begin
        rdata_q <= {mem[a0], mem[a1], mem[a2], mem[a3]};
        err_q   <= 1'b0;
      end
    end else if ((state == S_RESP) && bus.rsp_ready) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with WAIT_CYCLES=2 and one
// with WAIT_CYCLES=0. Inputs change 1ns after a rising edge and outputs are
// sampled there too, away from the active edge.
module tb_dmem_responder;

  logic       clk;
  logic       rst_n;
  logic       busy_a, busy_b;
  logic [1:0] state_a, state_b;
  int         n_cmp;
  int         n_fail;

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();

  dmem_responder #(.DEPTH_BYTES(32), .WAIT_CYCLES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_a),
    .busy      (busy_a),
    .state_dbg (state_a)
  );

  dmem_responder #(.DEPTH_BYTES(32), .WAIT_CYCLES(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_b),
    .busy      (busy_b),
    .state_dbg (state_b)
  );

  // Clock: 10ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: issue one request on bus_a with rsp_ready high; reports response,
  // edges from accept until rsp_valid, and req_ready after the response edge.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output logic ready_after);
    bus_a.req_we    = we;
    bus_a.req_addr  = addr;
    bus_a.req_wdata = wdata;
    bus_a.req_valid = 1'b1;
    @(posedge clk); #1;
    bus_a.req_valid = 1'b0;
    lat = 0;
    while (bus_a.rsp_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = bus_a.rsp_rdata;
    err   = bus_a.rsp_err;
    @(posedge clk); #1;
    ready_after = bus_a.req_ready;
  endtask

  task automatic test_reset();
    n_cmp++; if (bus_a.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", bus_a.req_ready); end
    n_cmp++; if (bus_a.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", bus_a.rsp_valid); end
    n_cmp++; if (bus_a.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h expected 00000000", bus_a.rsp_rdata); end
    n_cmp++; if (bus_a.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b expected 0", bus_a.rsp_err); end
    n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    n_cmp++; if (state_a !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_a); end
  endtask

  task automatic test_store_load();
    logic [31:0] rd;
    logic        er;
    logic        rdy;
    int          lat;
    do_req(1'b1, 32'd8, 32'hDEADBEEF, rd, er, lat, rdy);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL store_latency: got %0d expected 3", lat); end
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL store_rdata: got %h expected 00000000", rd); end
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL store_err: got %b expected 0", er); end
    n_cmp++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL store_ready_return: got %b expected 1", rdy); end
    n_cmp++; if (dut.mem[8] !== 8'hDE) begin n_fail++; $display("FAIL byte8: got %h expected de", dut.mem[8]); end
    n_cmp++; if (dut.mem[11] !== 8'hEF) begin n_fail++; $display("FAIL byte11: got %h expected ef", dut.mem[11]); end
    do_req(1'b0, 32'd8, 32'h0, rd, er, lat, rdy);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL load_latency: got %0d expected 3", lat); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_rdata: got %h expected deadbeef", rd); end
    // 0x12345668 has the same low five bits as byte address 8.
    do_req(1'b0, 32'h12345668, 32'h0, rd, er, lat, rdy);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL upper_addr_alias: got %h expected deadbeef", rd); end
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL upper_addr_err: got %b expected 0", er); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd;
    logic        er;
    logic        rdy;
    int          lat;
    do_req(1'b1, 32'd16, 32'h11223344, rd, er, lat, rdy);
    bus_a.rsp_ready = 1'b0;
    bus_a.req_we    = 1'b0;
    bus_a.req_addr  = 32'd16;
    bus_a.req_valid = 1'b1;
    @(posedge clk); #1;
    bus_a.req_valid = 1'b0;
    lat = 0;
    while (bus_a.rsp_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL bp_latency: got %0d expected 3", lat); end
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (bus_a.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_rsp_valid c%0d: got %b expected 1", c, bus_a.rsp_valid); end
      n_cmp++; if (bus_a.rsp_rdata !== 32'h11223344) begin n_fail++; $display("FAIL bp_rsp_rdata c%0d: got %h expected 11223344", c, bus_a.rsp_rdata); end
      n_cmp++; if (bus_a.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready c%0d: got %b expected 0", c, bus_a.req_ready); end
      // A store attempt during the held response must be ignored.
      bus_a.req_valid = (c == 2);
      bus_a.req_we    = 1'b1;
      bus_a.req_wdata = 32'h0;
      @(posedge clk); #1;
      bus_a.req_valid = 1'b0;
    end
    bus_a.rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus_a.req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", bus_a.req_ready); end
    n_cmp++; if (bus_a.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b expected 0", bus_a.rsp_valid); end
    do_req(1'b0, 32'd16, 32'h0, rd, er, lat, rdy);
    n_cmp++; if (rd !== 32'h11223344) begin n_fail++; $display("FAIL bp_pulse_ignored: got %h expected 11223344", rd); end
  endtask

`ifdef DMEM_ALIGN_CHECK_EN
  task automatic test_misaligned();
    logic [31:0] rd;
    logic        er;
    logic        rdy;
    int          lat;
    do_req(1'b1, 32'd6, 32'hCAFEF00D, rd, er, lat, rdy);
    n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL misalign_err: got %b expected 1", er); end
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL misalign_rdata: got %h expected 00000000", rd); end
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL misalign_latency: got %0d expected 3", lat); end
    do_req(1'b0, 32'd4, 32'h0, rd, er, lat, rdy);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL misalign_no_write: got %h expected 00000000", rd); end
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL aligned_err: got %b expected 0", er); end
    do_req(1'b0, 32'd9, 32'h0, rd, er, lat, rdy);
    n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL misalign_load_err: got %b expected 1", er); end
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL misalign_load_rdata: got %h expected 00000000", rd); end
  endtask
`else
  task automatic test_wrap();
    logic [31:0] rd;
    logic        er;
    logic        rdy;
    int          lat;
    do_req(1'b1, 32'd30, 32'hA1B2C3D4, rd, er, lat, rdy);
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL wrap_store_err: got %b expected 0", er); end
    n_cmp++; if (dut.mem[31] !== 8'hB2) begin n_fail++; $display("FAIL wrap_byte31: got %h expected b2", dut.mem[31]); end
    n_cmp++; if (dut.mem[1] !== 8'hD4) begin n_fail++; $display("FAIL wrap_byte1: got %h expected d4", dut.mem[1]); end
    do_req(1'b0, 32'd0, 32'h0, rd, er, lat, rdy);
    n_cmp++; if (rd !== 32'hC3D40000) begin n_fail++; $display("FAIL wrap_load0: got %h expected c3d40000", rd); end
    do_req(1'b0, 32'd30, 32'h0, rd, er, lat, rdy);
    n_cmp++; if (rd !== 32'hA1B2C3D4) begin n_fail++; $display("FAIL wrap_load30: got %h expected a1b2c3d4", rd); end
    // Unaligned load straddling the stored word at 8: bytes 11..14.
    do_req(1'b0, 32'd11, 32'h0, rd, er, lat, rdy);
    n_cmp++; if (rd !== 32'hEF000000) begin n_fail++; $display("FAIL unaligned_load11: got %h expected ef000000", rd); end
  endtask
`endif

  task automatic test_zero_wait();
    int lat;
    int accepts;
    bus_b.req_we    = 1'b0;
    bus_b.req_addr  = 32'd4;
    bus_b.req_valid = 1'b1;
    @(posedge clk); #1;
    bus_b.req_valid = 1'b0;
    lat = 0;
    while (bus_b.rsp_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL w0_latency: got %0d expected 1", lat); end
    n_cmp++; if (bus_b.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL w0_rdata: got %h expected 00000000", bus_b.rsp_rdata); end
    @(posedge clk); #1;
    // Held req_valid: accept, ACCESS, RESP, so an accept every third edge.
    accepts = 0;
    bus_b.req_valid = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (bus_b.req_ready === 1'b1) accepts++;
      @(posedge clk); #1;
    end
    bus_b.req_valid = 1'b0;
    n_cmp++; if (accepts !== 3) begin n_fail++; $display("FAIL w0_back_to_back: got %0d accepts expected 3", accepts); end
    n_cmp++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL w0_idle_after: got busy %b expected 0", busy_b); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd;
    logic        er;
    logic        rdy;
    int          lat;
    bus_a.req_we    = 1'b1;
    bus_a.req_addr  = 32'd12;
    bus_a.req_wdata = 32'hFFFFFFFF;
    bus_a.req_valid = 1'b1;
    @(posedge clk); #1;
    bus_a.req_valid = 1'b0;
    n_cmp++; if (state_a !== 2'd1) begin n_fail++; $display("FAIL rst_pre_state: got %0d expected 1", state_a); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy: got %b expected 0", busy_a); end
    n_cmp++; if (bus_a.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_async_ready: got %b expected 1", bus_a.req_ready); end
    n_cmp++; if (state_a !== 2'd0) begin n_fail++; $display("FAIL rst_async_state: got %0d expected 0", state_a); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 32'd12, 32'h0, rd, er, lat, rdy);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_discard_store: got %h expected 00000000", rd); end
    do_req(1'b0, 32'd8, 32'h0, rd, er, lat, rdy);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_clears_mem: got %h expected 00000000", rd); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_addr = '0; bus_a.req_wdata = '0; bus_a.rsp_ready = 1'b1;
    bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_addr = '0; bus_b.req_wdata = '0; bus_b.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_store_load();
    test_backpressure();
`ifdef DMEM_ALIGN_CHECK_EN
    test_misaligned();
`else
    test_wrap();
`endif
    test_zero_wait();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
